// File: rtl/stage5_fetch_unit.sv
// Fetch stage: PC register, instruction-bus request FSM, one-entry response
// hold buffer and the IF/DC pipeline latch feeding decode.
module stage5_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pc_en,
  input  logic        npc_sel,
  input  logic [31:0] brj_addr,
  input  logic        insert_priv_pc,
  input  logic [31:0] priv_pc,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        iren,
  input  logic        suppress_iren,
  input  logic        if_dc_stall,
  input  logic        if_dc_flush,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  output logic        i_mem_busy,
  output logic [31:0] pc_f,
  output logic [31:0] fault_addr_fetch,
  output logic [31:0] insn_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic        fault_insn_d,
  output logic        mal_insn_d
);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        hold_full_q, hold_full_d;
  logic [31:0] hold_insn_q, hold_insn_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        hold_fault_q, hold_fault_d;
  logic        dc_valid_q, dc_valid_d;
  logic [31:0] dc_insn_q, dc_insn_d;
  logic [31:0] dc_pc_q, dc_pc_d;
  logic        dc_fault_q, dc_fault_d;
  logic        dc_mal_q, dc_mal_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic        redirect;
  logic [31:0] redirect_addr;
  logic        misaligned_pc;
  logic        resp_accept;
  logic        resp_to_hold;
  logic        can_issue;
  logic        misalign_fault;

  assign redirect      = insert_priv_pc | rollback | npc_sel;
  assign redirect_addr = insert_priv_pc ? priv_pc : (rollback ? rollback_pc : brj_addr);
  assign misaligned_pc = |fetch_pc_q[1:0];
  assign resp_accept   = (state_q == REQ) & ~imem_busy & ~redirect;
  assign resp_to_hold  = resp_accept & if_dc_stall & ~if_dc_flush;
  // A response parked in the hold buffer this cycle also blocks a back-to-back request.
  assign can_issue     = iren & ~suppress_iren & ~redirect & ~hold_full_q & ~resp_to_hold;
  assign misalign_fault = (state_q == IDLE) & misaligned_pc & iren & ~redirect;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    if (redirect)   fetch_pc_d = redirect_addr;
    else if (pc_en) fetch_pc_d = fetch_pc_q + 32'd4;
    else            fetch_pc_d = fetch_pc_q;

    case (state_q)
      IDLE: begin
        if (can_issue && !misaligned_pc) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          state_d = imem_busy ? DISCARD : IDLE;
        end else if (!imem_busy) begin
          if (can_issue && fetch_pc_d[1:0] == 2'b00) begin
            state_d    = REQ;
            req_addr_d = fetch_pc_d;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (!imem_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_full_d  = hold_full_q;
    hold_insn_d  = hold_insn_q;
    hold_pc_d    = hold_pc_q;
    hold_fault_d = hold_fault_q;
    dc_valid_d   = dc_valid_q;
    dc_insn_d    = dc_insn_q;
    dc_pc_d      = dc_pc_q;
    dc_fault_d   = dc_fault_q;
    dc_mal_d     = dc_mal_q;
    fault_addr_d = fault_addr_q;

    if (resp_accept && imem_error) fault_addr_d = req_addr_q;

    if (if_dc_flush) begin
      dc_valid_d  = 1'b0;
      dc_insn_d   = NOP_INSN;
      dc_fault_d  = 1'b0;
      dc_mal_d    = 1'b0;
      hold_full_d = 1'b0;
    end else if (if_dc_stall) begin
      if (resp_to_hold) begin
        hold_full_d  = 1'b1;
        hold_insn_d  = imem_rdata;
        hold_pc_d    = req_addr_q;
        hold_fault_d = imem_error;
      end
    end else if (hold_full_q) begin
      dc_valid_d  = 1'b1;
      dc_insn_d   = hold_insn_q;
      dc_pc_d     = hold_pc_q;
      dc_fault_d  = hold_fault_q;
      dc_mal_d    = 1'b0;
      hold_full_d = 1'b0;
    end else if (resp_accept) begin
      dc_valid_d = 1'b1;
      dc_insn_d  = imem_rdata;
      dc_pc_d    = req_addr_q;
      dc_fault_d = imem_error;
      dc_mal_d   = 1'b0;
    end else if (misalign_fault) begin
      dc_valid_d   = 1'b1;
      dc_insn_d    = NOP_INSN;
      dc_pc_d      = fetch_pc_q;
      dc_fault_d   = 1'b0;
      dc_mal_d     = 1'b1;
      fault_addr_d = fetch_pc_q;
    end else begin
      dc_valid_d = 1'b0;
      dc_insn_d  = NOP_INSN;
      dc_fault_d = 1'b0;
      dc_mal_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_full_q  <= 1'b0;
      hold_insn_q  <= NOP_INSN;
      hold_pc_q    <= 32'd0;
      hold_fault_q <= 1'b0;
      dc_valid_q   <= 1'b0;
      dc_insn_q    <= NOP_INSN;
      dc_pc_q      <= 32'd0;
      dc_fault_q   <= 1'b0;
      dc_mal_q     <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      hold_full_q  <= hold_full_d;
      hold_insn_q  <= hold_insn_d;
      hold_pc_q    <= hold_pc_d;
      hold_fault_q <= hold_fault_d;
      dc_valid_q   <= dc_valid_d;
      dc_insn_q    <= dc_insn_d;
      dc_pc_q      <= dc_pc_d;
      dc_fault_q   <= dc_fault_d;
      dc_mal_q     <= dc_mal_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign imem_ren         = (state_q == REQ) || (state_q == DISCARD);
  assign imem_addr        = req_addr_q;
  assign i_mem_busy       = ~(resp_accept | hold_full_q | misaligned_pc);
  assign pc_f             = fetch_pc_q;
  assign fault_addr_fetch = fault_addr_q;
  assign insn_d           = dc_insn_q;
  assign pc_d             = dc_pc_q;
  assign valid_d          = dc_valid_q;
  assign fault_insn_d     = dc_fault_q;
  assign mal_insn_d       = dc_mal_q;

endmodule
